instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage between the program counter and the decode/execute datapath of the single-cycle RV32I core. Takes the current PC, runs a request/grant/response transaction on the instruction-memory port, and holds the fetched word for the consumer. It drives a one-cycle `pc_load` pulse, the PC's advance enable, when the consumer accepts the instruction. It also detects misaligned PCs, bus errors and memory timeouts, and counts delivered instructions.

## Interface

Parameters:
- TIMEOUT, 255, maximum cycles in WAIT without a response before a timeout fault (1..65535)

Ports:
- clk  in  1  clock, rising edge
- Areset  in  1  asynchronous, active-low reset
- en  in  1  fetch enable; sampled only in IDLE
- pc  in  32  current PC from the program counter
- pc_load  out  1  PC advance pulse (to PC `load`)
- imem_req  out  1  memory request
- imem_addr  out  32  request address (word-aligned)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- imem_err  in  1  bus error response
- instr  out  32  fetched instruction
- instr_pc  out  32  address of `instr`
- instr_valid  out  1  `instr` valid for consumer
- instr_ready  in  1  consumer accepts `instr`
- fault_clr  in  1  clears sticky fault
- fetch_fault  out  1  sticky fault flag
- fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout, 00 none
- instr_count  out  32  delivered-instruction counter

## Operation

- FSM states: IDLE, REQ, WAIT, VALID, FAULT.
- **IDLE**
  - If `en` and `pc[1:0]==0`: register `pc` into the address register and go to REQ.
  - If `en` and `pc[1:0]!=0`: go to FAULT with cause 01; `instr_pc` captures `pc`.
  - If `en` is low: stay in IDLE.
- **REQ**
  - `imem_req=1` and `imem_addr` come from the registered address. Both stay stable until `imem_gnt`.
  - On `imem_gnt`: clear the wait counter and go to WAIT.
  - `imem_rvalid` and `imem_err` are ignored in REQ.
- **WAIT**
  - `imem_req=0`. The wait counter increments every cycle.
  - `imem_err`: go to FAULT, cause 10. If `imem_err` and `imem_rvalid` arrive together, `imem_err` wins.
  - Otherwise, `imem_rvalid`: `instr` captures `imem_rdata`, `instr_pc` captures the address, go to VALID.
  - Otherwise, if the counter equals TIMEOUT: go to FAULT, cause 11. If `imem_rvalid` arrives on the timeout cycle, `imem_rvalid` wins.
- **VALID**
  - `instr_valid=1`; `instr` and `instr_pc` are held stable.
  - On `instr_ready`: `pc_load=1` combinationally in the same cycle, `instr_count` increments (wraps at 2^32), go to IDLE.
- **FAULT**
  - `fetch_fault=1` and `fault_cause` are held. No requests are issued and `pc_load=0`.
  - On `fault_clr`: `fault_cause` returns to 00 and the FSM goes to IDLE.
- `en` low does not abort a transaction in progress; it only blocks leaving IDLE.
- `pc_load` is asserted only in VALID with `instr_ready`, so the PC advances exactly once per delivered instruction.

## Timing

- **Reset values:** state IDLE; `pc_load`, `imem_req`, `instr_valid`, `fetch_fault` all 0; `fault_cause` 00; `imem_addr`, `instr`, `instr_pc`, `instr_count` all 0.
- **Reset mid-transaction:** any `imem_rvalid`/`imem_err` arriving after reset deasserts is ignored (state is IDLE).
- **Minimum fetch cycle** (gnt in the first REQ cycle, rvalid in the first WAIT cycle, ready immediate) is 4 cycles per instruction:
  - IDLE (1), REQ (1), WAIT (1), VALID (1).
  - The PC updates on the edge ending VALID.
  - IDLE samples the new `pc` in the following cycle.
- **Earliest response:** `imem_rvalid` is honoured no earlier than the cycle after `imem_gnt`.
- **Timeout boundary:** with no response, FAULT is entered on the edge after the WAIT cycle in which the counter reads TIMEOUT. That is TIMEOUT+1 cycles in WAIT.
- All outputs except `pc_load` are registered.

## Test plan

- **Basic fetch:** Areset low→high, `en=1`, `pc=0x0000_0000`, gnt immediate, rvalid one cycle later with `rdata=0x0000_0013`, ready=1 → `instr=0x13`, `instr_pc=0`, one `pc_load` pulse, `instr_count=1`, loop period 4 cycles.
- **Stalls:** gnt delayed 3 cycles, then `instr_ready` held low for 5 cycles → `imem_addr` stable throughout REQ, `instr` stable throughout VALID, no `pc_load` until ready.
- **Misaligned PC:** `pc=0x0000_0006` → FAULT with cause 01, `instr_pc=0x6`, no `imem_req`; `fault_clr` → IDLE.
- **Bus error and tie:** `imem_err` alone → cause 10; `imem_err` and `imem_rvalid` in the same cycle → cause 10, `instr` unchanged.
- **Timeout:** TIMEOUT=4, no rvalid → fault cause 11 after exactly 5 WAIT cycles; a separate run with rvalid on the 5th WAIT cycle → VALID, no fault.
- **Reset mid-WAIT:** Areset asserted while in WAIT, then rvalid after release → all outputs at reset values, rvalid ignored, `instr_count=0`.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
// The fetch unit is the master: it raises imem_req with a word-aligned
// imem_addr and holds both until imem_gnt. The memory answers later with
// imem_rvalid/imem_rdata or with imem_err.
//   imem_req    master -> slave  request pending
//   imem_addr   master -> slave  request address
//   imem_gnt    slave  -> master request accepted this cycle
//   imem_rvalid slave  -> master read data valid
//   imem_rdata  slave  -> master read data
//   imem_err    slave  -> master bus error response
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle RV32I core. It takes the current PC,
// runs one request/grant/response transaction on the instruction-memory
// bus and holds the fetched word until the consumer accepts it. On
// acceptance it pulses pc_load so that the PC advances exactly once per
// delivered instruction. Misaligned PCs, bus errors and missing responses
// are reported through a sticky fault flag with a cause code.
//   clk, Areset          clock (rising edge), async active-low reset
//   en                   fetch enable, only looked at while idle
//   pc                   current PC
//   pc_load              PC advance pulse (combinational, VALID & ready)
//   imem                 instruction-memory bus (master side)
//   instr, instr_pc      fetched word and its address
//   instr_valid          instr held for the consumer
//   instr_ready          consumer accepts instr
//   fault_clr            clears the sticky fault
//   fetch_fault          sticky fault flag
//   fault_cause          01 misaligned, 10 bus error, 11 timeout, 00 none
//   instr_count          delivered-instruction counter (wraps)
// TIMEOUT is the last wait-counter value tolerated in WAIT, so a silent
// memory is given TIMEOUT+1 WAIT cycles before the timeout fault.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      Areset,
    input  logic                      en,
    input  logic [31:0]               pc,
    output logic                      pc_load,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      fault_clr,
    output logic                      fetch_fault,
    output logic [1:0]                fault_cause,
    output logic [31:0]               instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [15:0] wait_cnt_r;
    logic        req_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic        instr_valid_r;
    logic        fault_r;
    logic [1:0]  cause_r;
    logic [31:0] count_r;
    logic        accept_s;

    // Consumer handshake completes only while the word is being offered.
    always_comb begin
        accept_s = 1'b0;
        if (state_r == ST_VALID) begin
            accept_s = instr_ready;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Fetch sequencer: state, bus request, captured instruction, fault and counter.
    always_ff @(posedge clk or negedge Areset) begin
        if (!Areset) begin
            state_r       <= ST_IDLE;
            addr_r        <= 32'd0;
            wait_cnt_r    <= 16'd0;
            req_r         <= 1'b0;
            instr_r       <= 32'd0;
            instr_pc_r    <= 32'd0;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            cause_r       <= CAUSE_NONE;
            count_r       <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        if (pc[1:0] == 2'b00) begin
                            addr_r  <= pc;
                            req_r   <= 1'b1;
                            state_r <= ST_REQ;
                        end else begin
                            instr_pc_r <= pc;
                            fault_r    <= 1'b1;
                            cause_r    <= CAUSE_MISALIGN;
                            state_r    <= ST_FAULT;
                        end
                    end
                end
                // Responses are not looked at here, so a response can be
                // honoured no earlier than the cycle after the grant.
                ST_REQ: begin
                    if (imem.imem_gnt) begin
                        req_r      <= 1'b0;
                        wait_cnt_r <= 16'd0;
                        state_r    <= ST_WAIT;
                    end
                end
                // Priority: bus error, then data, then timeout. Data on the
                // timeout cycle still completes the fetch.
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 16'd1;
                    if (imem.imem_err) begin
                        fault_r <= 1'b1;
                        cause_r <= CAUSE_BUS_ERR;
                        state_r <= ST_FAULT;
                    end else if (imem.imem_rvalid) begin
                        instr_r       <= imem.imem_rdata;
                        instr_pc_r    <= addr_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_VALID;
                    end else if (wait_cnt_r == TIMEOUT_C) begin
                        fault_r <= 1'b1;
                        cause_r <= CAUSE_TIMEOUT;
                        state_r <= ST_FAULT;
                    end
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        instr_valid_r <= 1'b0;
                        count_r       <= count_r + 32'd1;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_r <= 1'b0;
                        cause_r <= CAUSE_NONE;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a quiet idle.
                    req_r         <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fault_r       <= 1'b0;
                    cause_r       <= CAUSE_NONE;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_load        = accept_s;
    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign instr_valid    = instr_valid_r;
    assign fetch_fault    = fault_r;
    assign fault_cause    = cause_r;
    assign instr_count    = count_r;

endmodule
